// File: rtl/hack_pkg.sv
// Shared Hack boot definitions: sequencer states, memory geometry, word-count helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package hack_pkg;

   localparam int HACK_ROM_DEPTH = 32768;
   localparam int HACK_RAM_WORDS = 24576;
   localparam int HACK_ADDR_W    = 15;
   localparam int HACK_WORD_W    = 16;
   localparam int HACK_PTR_W     = 16;

   // Largest word count a single load can report (a completely full ROM).
   localparam logic [HACK_PTR_W-1:0] HACK_COUNT_MAX = 16'h8000;

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERR   = 3'd4
   } boot_state_t;

   // Increment that sticks at HACK_COUNT_MAX instead of wrapping.
   function automatic logic [HACK_PTR_W-1:0] sat_inc(input logic [HACK_PTR_W-1:0] v);
      if (v >= HACK_COUNT_MAX) begin
         return HACK_COUNT_MAX;
      end
      return v + 16'd1;
   endfunction

endpackage

// File: rtl/hack_cycle_counter.sv
// Loadable down-counter shared by the RAM-clear sequence and the reset-hold timer.
// Latency: count updates one cycle after load/dec; zero is combinational on the held count.
// Backpressure: none; dec is ignored once the count reaches zero.
module hack_cycle_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Load wins over decrement; decrement floors at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/hack_boot_ctrl.sv
// Hack boot sequencer: streams a program into ROM, zeroes RAM, holds CPU reset, then releases it.
// Latency: ROM write strobe/address/data appear the cycle after a transfer; all strobes registered.
// Backpressure: s_ready is high only in LOAD; the sender may stall s_valid for any number of cycles.
module hack_boot_ctrl
   import hack_pkg::*;
#(
   parameter int ROM_DEPTH       = HACK_ROM_DEPTH,
   parameter int RAM_CLEAR_DEPTH = HACK_RAM_WORDS,
   parameter int HOLD_CYCLES     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   boot_start,
   input  logic                   s_valid,
   input  logic [HACK_WORD_W-1:0] s_data,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic                   rom_we,
   output logic [HACK_ADDR_W-1:0] rom_addr,
   output logic [HACK_WORD_W-1:0] rom_wdata,
   output logic                   ram_we,
   output logic [HACK_ADDR_W-1:0] ram_addr,
   output logic                   cpu_reset,
   output logic                   busy,
   output logic                   error,
   output logic [HACK_PTR_W-1:0]  word_count
);

   // Counter preloads: the counter reaches zero on the final CLEAR address / final HOLD cycle.
   localparam logic [HACK_PTR_W-1:0] CLR_LOAD  = HACK_PTR_W'(RAM_CLEAR_DEPTH - 1);
   localparam logic [HACK_PTR_W-1:0] HOLD_LOAD = HACK_PTR_W'(HOLD_CYCLES - 1);
   localparam logic [HACK_PTR_W-1:0] LAST_PTR  = HACK_PTR_W'(ROM_DEPTH - 1);

   boot_state_t            state_q,     state_d;
   logic [HACK_PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
   logic [HACK_PTR_W-1:0]  word_count_q, word_count_d;
   logic                   rom_we_q,    rom_we_d;
   logic [HACK_ADDR_W-1:0] rom_addr_q,  rom_addr_d;
   logic [HACK_WORD_W-1:0] rom_wdata_q, rom_wdata_d;
   logic                   ram_we_q,    ram_we_d;
   logic [HACK_ADDR_W-1:0] ram_addr_q,  ram_addr_d;
   logic                   cpu_reset_q, cpu_reset_d;
   logic                   error_q,     error_d;

   logic                   xfer;
   logic                   cnt_load;
   logic [HACK_PTR_W-1:0]  cnt_load_val;
   logic                   cnt_dec;
   logic                   cnt_zero;

   assign s_ready = (state_q == ST_LOAD);
   assign xfer    = s_valid & s_ready;

   // One counter serves both timed phases since CLEAR and HOLD never overlap.
   hack_cycle_counter #(
      .W (HACK_PTR_W)
   ) u_cycle_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Next-state and registered-output logic; strobes default low every cycle.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      word_count_d = word_count_q;
      rom_we_d     = 1'b0;
      rom_addr_d   = rom_addr_q;
      rom_wdata_d  = rom_wdata_q;
      ram_addr_d   = ram_addr_q;
      error_d      = error_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (xfer) begin
               rom_we_d     = 1'b1;
               rom_addr_d   = wr_ptr_q[HACK_ADDR_W-1:0];
               rom_wdata_d  = s_data;
               wr_ptr_d     = wr_ptr_q + 16'd1;
               word_count_d = sat_inc(word_count_q);
               // s_last wins even on the very last ROM slot: a full image is legal.
               if (s_last) begin
                  cnt_load = 1'b1;
                  if (RAM_CLEAR_DEPTH == 0) begin
                     state_d      = ST_HOLD;
                     cnt_load_val = HOLD_LOAD;
                  end else begin
                     state_d      = ST_CLEAR;
                     cnt_load_val = CLR_LOAD;
                     ram_addr_d   = '0;
                  end
               end else if (wr_ptr_q == LAST_PTR) begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            if (cnt_zero) begin
               state_d      = ST_HOLD;
               cnt_load     = 1'b1;
               cnt_load_val = HOLD_LOAD;
            end else begin
               cnt_dec    = 1'b1;
               ram_addr_d = ram_addr_q + 15'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_d = ST_RUN;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_RUN: begin
            if (boot_start) begin
               state_d      = ST_LOAD;
               wr_ptr_d     = '0;
               word_count_d = '0;
            end
         end
         ST_ERR: begin
            if (boot_start) begin
               state_d      = ST_LOAD;
               wr_ptr_d     = '0;
               word_count_d = '0;
               error_d      = 1'b0;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase

      // Decoded from the next state so they change on the same edge as the state.
      ram_we_d    = (state_d == ST_CLEAR);
      cpu_reset_d = (state_d != ST_RUN);
   end

   // State and output registers; reset drops every strobe immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_LOAD;
         wr_ptr_q     <= '0;
         word_count_q <= '0;
         rom_we_q     <= 1'b0;
         rom_addr_q   <= '0;
         rom_wdata_q  <= '0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         cpu_reset_q  <= 1'b1;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         word_count_q <= word_count_d;
         rom_we_q     <= rom_we_d;
         rom_addr_q   <= rom_addr_d;
         rom_wdata_q  <= rom_wdata_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         cpu_reset_q  <= cpu_reset_d;
         error_q      <= error_d;
      end
   end

   assign rom_we     = rom_we_q;
   assign rom_addr   = rom_addr_q;
   assign rom_wdata  = rom_wdata_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign cpu_reset  = cpu_reset_q;
   assign error      = error_q;
   assign word_count = word_count_q;
   assign busy       = (state_q == ST_LOAD) || (state_q == ST_CLEAR) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_hack_boot_ctrl.sv
module tb_hack_boot_ctrl;

   localparam int TB_ROM  = 4096;
   localparam int TB_RAM  = 300;
   localparam int TB_HOLD = 4;

   typedef struct packed {
      logic [14:0] a;
      logic [15:0] d;
   } rw_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        boot_start = 1'b0;
   logic        s_valid = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        s_ready, rom_we, ram_we, cpu_reset, busy, error;
   logic [14:0] rom_addr, ram_addr;
   logic [15:0] rom_wdata, word_count;

   logic        z_boot_start = 1'b0;
   logic        z_s_valid = 1'b0;
   logic [15:0] z_s_data = '0;
   logic        z_s_last = 1'b0;
   logic        z_s_ready, z_rom_we, z_ram_we, z_cpu_reset, z_busy, z_error;
   logic [14:0] z_rom_addr, z_ram_addr;
   logic [15:0] z_rom_wdata, z_word_count;

   int          checks = 0;
   int          errors = 0;
   rw_t         exp_rom[$];
   logic [14:0] exp_ram[$];
   logic [15:0] img[$];
   rw_t         mon_e;
   logic [14:0] mon_a;
   int          z_ram_seen = 0;
   int          z_rom_seen = 0;
   logic [14:0] z_last_addr = '0;
   logic [15:0] z_last_data = '0;

   always #5 clk = ~clk;

   hack_boot_ctrl #(
      .ROM_DEPTH       (TB_ROM),
      .RAM_CLEAR_DEPTH (TB_RAM),
      .HOLD_CYCLES     (TB_HOLD)
   ) u_dut (
      .clk (clk), .reset (reset), .boot_start (boot_start),
      .s_valid (s_valid), .s_data (s_data), .s_last (s_last), .s_ready (s_ready),
      .rom_we (rom_we), .rom_addr (rom_addr), .rom_wdata (rom_wdata),
      .ram_we (ram_we), .ram_addr (ram_addr), .cpu_reset (cpu_reset),
      .busy (busy), .error (error), .word_count (word_count)
   );

   hack_boot_ctrl #(
      .ROM_DEPTH       (TB_ROM),
      .RAM_CLEAR_DEPTH (0),
      .HOLD_CYCLES     (TB_HOLD)
   ) u_dut_noclr (
      .clk (clk), .reset (reset), .boot_start (z_boot_start),
      .s_valid (z_s_valid), .s_data (z_s_data), .s_last (z_s_last), .s_ready (z_s_ready),
      .rom_we (z_rom_we), .rom_addr (z_rom_addr), .rom_wdata (z_rom_wdata),
      .ram_we (z_ram_we), .ram_addr (z_ram_addr), .cpu_reset (z_cpu_reset),
      .busy (z_busy), .error (z_error), .word_count (z_word_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (rom_we === 1'b1) begin
            if (exp_rom.size() == 0) begin
               check("rom_we_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = exp_rom.pop_front();
               check("rom_addr", 32'(rom_addr), 32'(mon_e.a));
               check("rom_wdata", 32'(rom_wdata), 32'(mon_e.d));
            end
         end
         if (ram_we === 1'b1) begin
            if (exp_ram.size() == 0) begin
               check("ram_we_unexpected", 32'd1, 32'd0);
            end else begin
               mon_a = exp_ram.pop_front();
               check("ram_addr", 32'(ram_addr), 32'(mon_a));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (z_ram_we === 1'b1) z_ram_seen++;
         if (z_rom_we === 1'b1) begin
            z_rom_seen++;
            z_last_addr = z_rom_addr;
            z_last_data = z_rom_wdata;
         end
      end
   end

   // Reference model of a clear phase: every RAM address from 0 upward, once each.
   task automatic expect_clear();
      for (int k = 0; k < TB_RAM; k++) exp_ram.push_back(15'(k));
   endtask

   // Streams img[]; each accepted word is expected in ROM at its image index.
   // gap_mode: 0 back-to-back, 1 valid toggling every cycle, 2 random stalls plus stray boot_start.
   task automatic send_image(input bit with_last, input int gap_mode);
      int  i = 0;
      bit  idle_next = 1'b0;
      rw_t e;
      while (i < img.size()) begin
         @(negedge clk);
         check("s_ready_in_load", 32'(s_ready), 32'd1);
         boot_start = (gap_mode == 2) && ($urandom_range(0, 7) == 0);
         if ((gap_mode == 1 && idle_next) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            s_valid   = 1'b0;
            s_last    = 1'b0;
            s_data    = 16'($urandom);
            idle_next = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = img[i];
            s_last  = with_last && (i == img.size() - 1);
            e.a     = 15'(i);
            e.d     = img[i];
            exp_rom.push_back(e);
            i++;
            idle_next = 1'b1;
         end
      end
      @(negedge clk);
      s_valid    = 1'b0;
      s_last     = 1'b0;
      boot_start = 1'b0;
   endtask

   // Called one cycle after the final transfer; measures cycles from that transfer to CPU release.
   task automatic wait_run(input int exp_cyc, input int pulse_at);
      int c = 1;
      while (cpu_reset !== 1'b0 && c < exp_cyc + 100) begin
         @(negedge clk);
         c++;
         boot_start = (c == pulse_at);
      end
      boot_start = 1'b0;
      check("run_latency", 32'(c), 32'(exp_cyc));
      check("busy_in_run", 32'(busy), 32'd0);
      check("rom_q_drained", 32'(exp_rom.size()), 32'd0);
      check("ram_q_drained", 32'(exp_ram.size()), 32'd0);
   endtask

   task automatic do_boot();
      @(negedge clk);
      boot_start = 1'b1;
      @(negedge clk);
      boot_start = 1'b0;
      check("boot_cpu_reset", 32'(cpu_reset), 32'd1);
      check("boot_s_ready", 32'(s_ready), 32'd1);
      check("boot_word_count", 32'(word_count), 32'd0);
      check("boot_error", 32'(error), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int n;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_error", 32'(error), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_rom_we", 32'(rom_we), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);

      // No-clear build: one-word image goes straight to HOLD then RUN.
      @(negedge clk);
      z_s_valid = 1'b1;
      z_s_data  = 16'hA5C3;
      z_s_last  = 1'b1;
      check("z_s_ready", 32'(z_s_ready), 32'd1);
      @(negedge clk);
      c = 1;
      z_s_valid = 1'b0;
      z_s_last  = 1'b0;
      check("z_s_ready_drop", 32'(z_s_ready), 32'd0);
      check("z_busy_hold", 32'(z_busy), 32'd1);
      check("z_cpu_reset_hold", 32'(z_cpu_reset), 32'd1);
      while (z_cpu_reset !== 1'b0 && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("z_run_latency", 32'(c), 32'(1 + TB_HOLD));
      check("z_ram_we_count", 32'(z_ram_seen), 32'd0);
      check("z_rom_we_count", 32'(z_rom_seen), 32'd1);
      check("z_rom_addr", 32'(z_last_addr), 32'd0);
      check("z_rom_wdata", 32'(z_last_data), 32'hA5C3);
      check("z_word_count", 32'(z_word_count), 32'd1);
      check("z_error", 32'(z_error), 32'd0);
      check("z_ram_addr", 32'(z_ram_addr), 32'd0);

      // Three-word program; boot_start during HOLD must not disturb the release timing.
      img = '{16'h0002, 16'hEC10, 16'h0000};
      expect_clear();
      send_image(1'b1, 0);
      wait_run(TB_RAM + TB_HOLD + 1, TB_RAM + 2);
      check("t1_word_count", 32'(word_count), 32'd3);

      // Restart from RUN, then 8 words with s_valid toggling every cycle.
      do_boot();
      img.delete();
      for (int k = 0; k < 8; k++) img.push_back(16'($urandom));
      expect_clear();
      send_image(1'b1, 1);
      wait_run(TB_RAM + TB_HOLD + 1, -1);
      check("t3_word_count", 32'(word_count), 32'd8);

      // Random images with stalls; boot_start pulses in LOAD, CLEAR or HOLD are ignored.
      for (int r = 0; r < 4; r++) begin
         do_boot();
         img.delete();
         n = $urandom_range(1, 16);
         for (int k = 0; k < n; k++) img.push_back(16'($urandom));
         expect_clear();
         send_image(1'b1, 2);
         wait_run(TB_RAM + TB_HOLD + 1, $urandom_range(2, TB_RAM + TB_HOLD));
         check("rand_word_count", 32'(word_count), 32'(n));
      end

      // Full ROM with s_last on the final slot: legal.
      do_boot();
      img.delete();
      for (int k = 0; k < TB_ROM; k++) img.push_back(16'($urandom));
      expect_clear();
      send_image(1'b1, 0);
      check("full_error", 32'(error), 32'd0);
      wait_run(TB_RAM + TB_HOLD + 1, -1);
      check("full_word_count", 32'(word_count), 32'(TB_ROM));

      // Full ROM without s_last: overflow error, last word still written.
      do_boot();
      img.delete();
      for (int k = 0; k < TB_ROM; k++) img.push_back(16'($urandom));
      send_image(1'b0, 0);
      check("ovf_error", 32'(error), 32'd1);
      check("ovf_s_ready", 32'(s_ready), 32'd0);
      check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
      check("ovf_busy", 32'(busy), 32'd0);
      check("ovf_word_count", 32'(word_count), 32'(TB_ROM));
      repeat (3) @(negedge clk);
      check("ovf_error_sticky", 32'(error), 32'd1);
      check("ovf_rom_q_drained", 32'(exp_rom.size()), 32'd0);
      do_boot();

      // Reset mid-CLEAR at address 100: strobes drop without a clock edge.
      img = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
      expect_clear();
      send_image(1'b1, 0);
      c = 0;
      while (ram_addr !== 15'd100 && c < 1000) begin
         @(negedge clk);
         c++;
      end
      check("clear_reached_100", 32'(ram_addr), 32'd100);
      #2 reset = 1'b1;
      #1;
      check("async_ram_we", 32'(ram_we), 32'd0);
      check("async_cpu_reset", 32'(cpu_reset), 32'd1);
      check("async_word_count", 32'(word_count), 32'd0);
      exp_ram.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_s_ready", 32'(s_ready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd1);
      check("post_rst_word_count", 32'(word_count), 32'd0);
      check("post_rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("post_rst_ram_we", 32'(ram_we), 32'd0);
      check("post_rst_error", 32'(error), 32'd0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
